// File: rtl/ow_pkg.sv
// Shared 1-Wire master definitions: op codes, FSM states, slot timing and CRC polynomial.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ow_pkg;

  typedef enum logic [1:0] {
    OW_RESET = 2'd0,
    OW_WRITE = 2'd1,
    OW_READ  = 2'd2,
    OW_RSVD  = 2'd3
  } ow_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_SLOT_W,
    ST_SLOT_R,
    ST_NOP
  } ow_state_e;

  localparam int T_SHORT_US  = 6;
  localparam int T_SAMPLE_US = 14;
  localparam int T_LOW0_US   = 60;
  localparam int T_SLOT_US   = 70;
  localparam int T_PRES_US   = 70;

  // Dallas/Maxim CRC-8, x^8+x^5+x^4+1 in reflected form
  localparam logic [7:0] CRC_POLY = 8'h8C;

  function automatic int wr_low_us(input logic b);
    return b ? T_SHORT_US : T_LOW0_US;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8, one bit per enabled cycle, LSB-first data order.
// Latency: crc reflects bit_in the cycle after en.
// Backpressure: none; clr has priority over en.
module onewire_crc8
  import ow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[0] ^ bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= (crc >> 1) ^ (fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/onewire_master_gen.sv
// 1-Wire bus master: reset/presence, byte write and N-byte read bursts with running CRC-8.
// Latency: done one cycle after the last slot ends (RESET 2*T_RSTL_US, WRITE 8 slots, READ 8*len slots).
// Backpressure: cmd_ready low while busy; cmd_valid without cmd_ready is ignored.
module onewire_master_gen
  import ow_pkg::*;
#(
  parameter int CLK_MHZ   = 50,
  parameter int MAX_BYTES = 9,
  parameter int T_RSTL_US = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       presence,
  output logic       crc_ok,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       dq_out
);

  localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int UW = $clog2(2*T_RSTL_US + T_SLOT_US + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);

  localparam logic [PW-1:0] PRE_MAX     = PW'(CLK_MHZ - 1);
  localparam logic [UW-1:0] RST_LOW_END = UW'(T_RSTL_US - 1);
  localparam logic [UW-1:0] RST_END     = UW'(2*T_RSTL_US - 1);
  localparam logic [UW-1:0] SLOT_END    = UW'(T_SLOT_US - 1);
  localparam logic [UW-1:0] PRES_US     = UW'(T_RSTL_US + T_PRES_US);
  localparam logic [UW-1:0] SAMP_US     = UW'(T_SAMPLE_US);

  ow_state_e       state;
  ow_op_e          op;
  logic [PW-1:0]   pre;
  logic [UW-1:0]   us_cnt;
  logic [UW-1:0]   us_nxt;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   byte_cnt;
  logic [BW-1:0]   len_q;
  logic [BW-1:0]   len_clamp;
  logic [7:0]      wr_q;
  logic [7:0]      rd_sr;
  logic [7:0]      crc;
  logic            accept;
  logic            pre_wrap;
  logic            us_start;
  logic            slot_end;
  logic            rd_sample;
  logic            crc_clr;
  int              low_us;

  assign op      = ow_op_e'(cmd_op);
  assign dq_out  = 1'b0;
  assign rd_data = rd_sr;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    pre_wrap  = (pre == PRE_MAX);
    us_start  = (pre == '0);
    us_nxt    = pre_wrap ? us_cnt + UW'(1) : us_cnt;
    slot_end  = pre_wrap && (us_cnt == ((state == ST_RST_WAIT) ? RST_END : SLOT_END));
    rd_sample = (state == ST_SLOT_R) && us_start && (us_cnt == SAMP_US);
    crc_clr   = accept && (op == OW_READ);
    low_us    = (state == ST_SLOT_W) ? wr_low_us(wr_q[bit_idx]) : T_SHORT_US;
    if (cmd_len == 4'd0) begin
      len_clamp = BW'(1);
    end else if (int'(cmd_len) > MAX_BYTES) begin
      len_clamp = BW'(MAX_BYTES);
    end else begin
      len_clamp = BW'(cmd_len);
    end
  end

  onewire_crc8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (rd_sample),
    .bit_in (dq_in),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      pre       <= '0;
      us_cnt    <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      wr_q      <= 8'h00;
      rd_sr     <= 8'h00;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      presence  <= 1'b0;
      crc_ok    <= 1'b0;
      dq_oe     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (state != ST_IDLE && state != ST_NOP) begin
        pre    <= pre_wrap ? '0 : pre + PW'(1);
        us_cnt <= us_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            pre       <= '0;
            us_cnt    <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            case (op)
              OW_RESET: begin state <= ST_RST_LOW; dq_oe <= 1'b1; end
              OW_WRITE: begin state <= ST_SLOT_W; wr_q <= wr_data; dq_oe <= 1'b1; end
              OW_READ:  begin state <= ST_SLOT_R; len_q <= len_clamp; dq_oe <= 1'b1; end
              default:  state <= ST_NOP;
            endcase
          end
        end
        ST_NOP: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RST_LOW: begin
          dq_oe <= (int'(us_nxt) < T_RSTL_US);
          if (pre_wrap && us_cnt == RST_LOW_END) state <= ST_RST_WAIT;
        end
        ST_RST_WAIT: begin
          // 1 on the bus at sample time means nobody answered
          if (us_start && us_cnt == PRES_US) presence <= ~dq_in;
          if (slot_end) begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_SLOT_W, ST_SLOT_R: begin
          if (rd_sample) rd_sr <= {dq_in, rd_sr[7:1]};
          dq_oe <= (int'(us_nxt) < low_us);
          if (slot_end) begin
            pre     <= '0;
            us_cnt  <= '0;
            bit_idx <= bit_idx + 3'd1;
            dq_oe   <= 1'b1;
            if (bit_idx == 3'd7) begin
              if (state == ST_SLOT_R) begin
                rd_valid <= 1'b1;
                byte_cnt <= byte_cnt + BW'(1);
              end
              if (state == ST_SLOT_W || byte_cnt == len_q - BW'(1)) begin
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                dq_oe     <= 1'b0;
                state     <= ST_IDLE;
                if (state == ST_SLOT_R) crc_ok <= (crc == 8'h00);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_master_gen.sv
// Scoreboard bench for onewire_master_gen with a behavioural 1-Wire slave on the bus.
// Latency: n/a. Backpressure: commands wait for cmd_ready.
// Expected results are queued at issue; monitors pop them on dq_oe falls, rd_valid and done.
module tb_onewire_master_gen;

  localparam int US = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       cmd_ready, rd_valid, done, presence, crc_ok, dq_oe, dq_out, dq_in;
  logic [7:0] rd_data;
  logic       slave_pull = 1'b0;

  assign dq_in = !(dq_oe || slave_pull);

  always #5 clk = ~clk;

  onewire_master_gen #(.CLK_MHZ(US), .MAX_BYTES(9), .T_RSTL_US(480)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .presence  (presence),
    .crc_ok    (crc_ok),
    .dq_in     (dq_in),
    .dq_oe     (dq_oe),
    .dq_out    (dq_out)
  );

  typedef struct {
    int   lat;
    logic chk_pres;
    logic pres;
    logic chk_crc;
    logic crc;
  } done_exp_t;

  done_exp_t  done_q[$];
  int         pulse_q[$];
  logic [7:0] rd_q[$];
  logic       s_bits[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int n_done_exp = 0;
  int s_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int val);
    n_chk++;
    n_fail++;
    $display("FAIL %s: value %0d", name, val);
  endtask

  always @(posedge clk) cyc++;

  // Slave: presence pulse at 520..640us after the reset edge, or read-slot replies
  int   s_cyc = 0;
  logic s_prev = 1'b0;
  logic s_bit = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_prev = 1'b0;
      slave_pull = 1'b0;
    end else begin
      if (dq_oe && !s_prev) begin
        s_cyc = 0;
        if (s_mode == 2) begin
          if (s_bits.size() > 0) s_bit = s_bits.pop_front();
          else s_bit = 1'b1;
        end
      end else if (s_cyc < 100000) begin
        s_cyc++;
      end
      s_prev = dq_oe;
      case (s_mode)
        1:       slave_pull = (s_cyc >= 520*US) && (s_cyc < 640*US);
        2:       slave_pull = !s_bit && (s_cyc < 30*US);
        default: slave_pull = 1'b0;
      endcase
    end
  end

  int   hi = 0;
  logic p_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hi = 0;
      p_prev = 1'b0;
    end else begin
      if (dq_oe) begin
        hi++;
      end else if (p_prev) begin
        if (pulse_q.size() == 0) flag("pulse_unexpected", hi);
        else check("pulse_len", hi, pulse_q.pop_front());
        hi = 0;
      end
      p_prev = dq_oe;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (rd_q.size() == 0) flag("rd_valid_unexpected", int'(rd_data));
      else check("rd_data", rd_data, rd_q.pop_front());
    end
  end

  done_exp_t de;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        flag("done_unexpected", cyc - acc_cyc);
      end else begin
        de = done_q.pop_front();
        check("done_lat", cyc - acc_cyc, de.lat);
        check("ready_at_done", cmd_ready, 1);
        if (de.chk_pres) check("presence", presence, de.pres);
        if (de.chk_crc) check("crc_ok", crc_ok, de.crc);
      end
    end
  end

  task automatic exp_done(input int lat, input logic cp, input logic p, input logic cc, input logic c);
    done_exp_t e;
    e.lat = lat; e.chk_pres = cp; e.pres = p; e.chk_crc = cc; e.crc = c;
    done_q.push_back(e);
    n_done_exp++;
  endtask

  task automatic slave_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) s_bits.push_back(b[i]);
    rd_q.push_back(b);
    for (int i = 0; i < 8; i++) pulse_q.push_back(12);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] len, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("issue_timeout", n);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; wr_data = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    wr_data = 8'h00;
    @(negedge clk);
    check("ready_drop", cmd_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt < n_done_exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < n_done_exp) flag("done_timeout", n);
  endtask

  int w_cc[8] = '{120, 120, 12, 12, 120, 120, 12, 12};
  int w_a5[8] = '{12, 120, 12, 120, 120, 12, 120, 12};
  logic [7:0] pad[9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_presence", presence, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_dq_out", dq_out, 0);
    rst_n = 1'b1;

    // RESET with a slave answering
    s_mode = 1;
    pulse_q.push_back(960);
    exp_done(1920, 1, 1, 0, 0);
    issue(2'd0, 4'd0, 8'h00);
    wait_done(4000);

    // RESET with an empty bus, then a WRITE
    s_mode = 0;
    pulse_q.push_back(960);
    exp_done(1920, 1, 0, 0, 0);
    issue(2'd0, 4'd0, 8'h00);
    wait_done(4000);
    for (int i = 0; i < 8; i++) pulse_q.push_back(w_a5[i]);
    exp_done(1120, 0, 0, 0, 0);
    issue(2'd1, 4'd0, 8'hA5);
    wait_done(2000);

    // WRITE 0xCC; a command offered while busy must be ignored
    for (int i = 0; i < 8; i++) pulse_q.push_back(w_cc[i]);
    exp_done(1120, 0, 0, 0, 0);
    issue(2'd1, 4'd0, 8'hCC);
    repeat (200) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 4'd1;
    repeat (5) @(negedge clk);
    check("busy_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_done(2000);

    // READ len=2, then len=0 clamps to one byte
    s_mode = 2;
    slave_byte(8'h50);
    slave_byte(8'h05);
    exp_done(2240, 0, 0, 0, 0);
    issue(2'd2, 4'd2, 8'h00);
    wait_done(3000);
    slave_byte(8'h3C);
    exp_done(1120, 0, 0, 0, 0);
    issue(2'd2, 4'd0, 8'h00);
    wait_done(2000);

    // DS18B20 power-on scratchpad: good CRC, then one corrupted bit
    for (int i = 0; i < 9; i++) slave_byte(pad[i]);
    exp_done(10080, 0, 0, 1, 1);
    issue(2'd2, 4'd9, 8'h00);
    wait_done(12000);
    slave_byte(8'h51);
    for (int i = 1; i < 9; i++) slave_byte(pad[i]);
    exp_done(10080, 0, 0, 1, 0);
    issue(2'd2, 4'd9, 8'h00);
    wait_done(12000);

    // Abort a WRITE with rst_n; no done may follow
    s_mode = 0;
    issue(2'd1, 4'd0, 8'h00);
    repeat (50) @(negedge clk);
    check("abort_pre_oe", dq_oe, 1);
    rst_n = 1'b0;
    #1;
    check("abort_oe", dq_oe, 0);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1);
    repeat (300) @(negedge clk);
    check("abort_oe_idle", dq_oe, 0);

    // Reserved op: accepted, nothing driven, done one cycle later
    exp_done(1, 0, 0, 0, 0);
    issue(2'd3, 4'd0, 8'h00);
    wait_done(20);
    repeat (5) @(negedge clk);

    check("pulse_q_empty", pulse_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
